// File: rtl/phase_sched_pkg.sv
// Shared definitions for the quadrature slot scheduler: phase encodings,
// one-hot encoding and rotating-priority pick helpers.
package phase_sched_pkg;

  localparam int N_PH = 4;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  // Result of a rotating-priority search.
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } pick_t;

  // Encode a phase index as a one-hot grant vector.
  function automatic logic [N_PH-1:0] onehot4(input logic [1:0] idx);
    logic [N_PH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set bit of req, searching base, base+1, base+2, base+3 (mod 4).
  // The loop runs from the farthest offset down so the nearest one wins.
  function automatic pick_t rot_pick(input logic [1:0] base,
                                     input logic [N_PH-1:0] req);
    pick_t      r;
    logic [1:0] i;
    r = '0;
    for (int k = N_PH - 1; k >= 0; k--) begin
      i = base + 2'(k);
      if (req[i]) begin
        r.vld = 1'b1;
        r.idx = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_slot_counter.sv
// Slot timebase: counts SLOT_LEN cycles per slot, advances the 2-bit phase
// on every boundary and emits a registered slot_start pulse. Counting
// freezes while en is low.
module phase_slot_counter
  import phase_sched_pkg::*;
#(
  parameter int SLOT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] phase,
  output logic       boundary,
  output logic       slot_start
);

  localparam int SC_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOT_LEN - 1);

  logic [SC_W-1:0] sc;

  // Last cycle of a slot while enabled; reset parks sc here so the first
  // enabled cycle after reset enters slot 0.
  assign boundary = en && (sc == SC_LAST);

  // Slot counter, phase register and slot_start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc         <= SC_LAST;
      phase      <= PH_270;
      slot_start <= 1'b0;
    end else begin
      slot_start <= boundary;
      if (boundary) begin
        sc    <= '0;
        phase <= phase + 2'd1;
      end else if (en) begin
        sc <= sc + SC_W'(1);
      end
    end
  end

endmodule

// File: rtl/phase_slot_arbiter.sv
// Time-division arbiter: four requesters each own one quadrant slot of a
// 4-slot frame. Optional macro PHASE_STEAL_EN makes it work-conserving by
// lending an unused slot to the next requester in rotation.
//
// Request/grant protocol: req[i] is a level held by requester i for as long
// as it wants the resource. gnt is registered, one-hot or zero, and is only
// decided on a slot boundary. Dropping req while granted releases gnt on
// the next cycle and the slot then stays idle until the next boundary.
module phase_slot_arbiter
  import phase_sched_pkg::*;
#(
  parameter int SLOT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       phase,
  output logic             slot_start,
  output logic             gnt_stolen,
  output logic [CNT_W-1:0] idle_cnt
);

  logic       boundary;
  logic [1:0] owner;
  logic       new_vld;
  logic [1:0] new_idx;
  logic       new_stolen;
  logic       slot_granted;  // current slot received a grant at its start
  logic       first_slot;    // no boundary seen since reset

  phase_slot_counter #(
    .SLOT_LEN(SLOT_LEN)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .phase     (phase),
    .boundary  (boundary),
    .slot_start(slot_start)
  );

  // The slot being entered belongs to the next phase.
  assign owner = phase + 2'd1;

`ifdef PHASE_STEAL_EN
  pick_t pick;

  // Owner first, otherwise the nearest active requester after it.
  always_comb begin
    pick       = rot_pick(owner, req);
    new_vld    = pick.vld;
    new_idx    = pick.idx;
    new_stolen = pick.vld && (pick.idx != owner);
  end
`else
  // Strict TDM: only the owner may use its slot; stolen never sets.
  always_comb begin
    new_vld    = req[owner];
    new_idx    = owner;
    new_stolen = 1'b0;
  end
`endif

  // Grant decision on boundaries, release on req drop or disable, and
  // saturating count of slots that closed without ever being granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt          <= '0;
      gnt_stolen   <= 1'b0;
      slot_granted <= 1'b0;
      first_slot   <= 1'b1;
      idle_cnt     <= '0;
    end else if (boundary) begin
      gnt          <= new_vld ? onehot4(new_idx) : 4'b0000;
      gnt_stolen   <= new_vld && new_stolen;
      slot_granted <= new_vld;
      first_slot   <= 1'b0;
      if (!first_slot && !slot_granted && (idle_cnt != '1)) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end else if (!en || ((gnt & ~req) != 4'b0000)) begin
      gnt        <= '0;
      gnt_stolen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_slot_arbiter.sv
// Directed bench for phase_slot_arbiter with SLOT_LEN=4, CNT_W=8.
// Cycle k means the interval just after the k-th rising edge following the
// cycle in which en was first raised (cycle 0 is the first boundary).
module tb_phase_slot_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] phase;
  logic       slot_start;
  logic       gnt_stolen;
  logic [7:0] idle_cnt;

  int total = 0;
  int bad   = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  phase_slot_arbiter #(
    .SLOT_LEN(4),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .phase     (phase),
    .slot_start(slot_start),
    .gnt_stolen(gnt_stolen),
    .idle_cnt  (idle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    req = 4'b0000;
    tick(2);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state.
    tick(2);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_ss", slot_start, 1'b0);
    check("rst_stolen", gnt_stolen, 1'b0);
    check("rst_idle", idle_cnt, 8'd0);
    check("rst_phase", phase, 2'd3);
    rst = 1'b1;

    // All requesting: each slot goes to its owner, one frame and a bit.
    en  = 1'b1;
    req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      int slot;
      tick(1);
      slot = ((c - 1) / 4) % 4;
      check("all_ss", slot_start, ((c - 1) % 4) == 0);
      check("all_gnt", gnt, 4'b0001 << slot);
      check("all_phase", phase, slot);
    end
    check("all_idle", idle_cnt, 8'd0);

    // Mid-slot release of requester 1, then en=0 inside slot 2.
    do_reset();
    en  = 1'b1;
    req = 4'b1111;
    tick(6);
    check("rel_c6_gnt", gnt, 4'b0010);
    req = 4'b1101;
    tick(1);
    check("rel_c7_gnt", gnt, 4'b0000);
    req = 4'b1111;
    tick(1);
    check("rel_c8_gnt", gnt, 4'b0000);
    tick(1);
    check("rel_c9_gnt", gnt, 4'b0100);
    check("rel_c9_ss", slot_start, 1'b1);
    check("rel_c9_phase", phase, 2'd2);
    tick(1);
    check("en_c10_gnt", gnt, 4'b0100);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("en_off_gnt", gnt, 4'b0000);
      check("en_off_phase", phase, 2'd2);
      check("en_off_ss", slot_start, 1'b0);
    end
    en = 1'b1;
    tick(1);
    check("en_c17_gnt", gnt, 4'b0000);
    tick(1);
    check("en_c18_gnt", gnt, 4'b0000);
    check("en_c18_phase", phase, 2'd2);
    tick(1);
    check("en_c19_gnt", gnt, 4'b1000);
    check("en_c19_ss", slot_start, 1'b1);
    check("en_c19_phase", phase, 2'd3);
    check("en_c19_idle", idle_cnt, 8'd0);

    // Only requester 0: three idle slots per frame, saturating at 255.
    do_reset();
    en  = 1'b1;
    req = 4'b0001;
    tick(1);
    check("sat_c1_gnt", gnt, 4'b0001);
    check("sat_c1_idle", idle_cnt, 8'd0);
    tick(4);
    check("sat_c5_gnt", gnt, 4'b0000);
    check("sat_c5_phase", phase, 2'd1);
    check("sat_c5_idle", idle_cnt, 8'd0);
    tick(4);
    check("sat_c9_idle", idle_cnt, 8'd1);
    tick(4);
    check("sat_c13_idle", idle_cnt, 8'd2);
    tick(4);
    check("sat_c17_idle", idle_cnt, 8'd3);
    check("sat_c17_gnt", gnt, 4'b0001);
    tick(16 * 83);
    check("sat_f84_idle", idle_cnt, 8'd252);
    tick(16 * 6);
    check("sat_f90_idle", idle_cnt, 8'd255);
    check("sat_f90_gnt", gnt, 4'b0001);
    check("sat_f90_ss", slot_start, 1'b1);

    // Asynchronous reset in the middle of a grant.
    #2;
    rst = 1'b0;
    #1;
    check("arst_gnt", gnt, 4'b0000);
    check("arst_ss", slot_start, 1'b0);
    check("arst_idle", idle_cnt, 8'd0);
    check("arst_phase", phase, 2'd3);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("arst_rel_phase", phase, 2'd0);
    check("arst_rel_gnt", gnt, 4'b0001);
    check("arst_rel_ss", slot_start, 1'b1);

    // Only requester 2: stolen slots with PHASE_STEAL_EN, idle otherwise.
    do_reset();
    en  = 1'b1;
    req = 4'b0100;
`ifdef PHASE_STEAL_EN
    tick(1);
    check("r2_c1_gnt", gnt, 4'b0100);
    check("r2_c1_stolen", gnt_stolen, 1'b1);
    tick(4);
    check("r2_c5_gnt", gnt, 4'b0100);
    check("r2_c5_stolen", gnt_stolen, 1'b1);
    tick(4);
    check("r2_c9_gnt", gnt, 4'b0100);
    check("r2_c9_stolen", gnt_stolen, 1'b0);
    tick(8);
    check("r2_c17_idle", idle_cnt, 8'd0);
`else
    tick(1);
    check("r2_c1_gnt", gnt, 4'b0000);
    check("r2_c1_stolen", gnt_stolen, 1'b0);
    tick(4);
    check("r2_c5_gnt", gnt, 4'b0000);
    tick(4);
    check("r2_c9_gnt", gnt, 4'b0100);
    check("r2_c9_stolen", gnt_stolen, 1'b0);
    tick(8);
    check("r2_c17_idle", idle_cnt, 8'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
